bomb_scheduler: RTL and testbench
=================================

# bomb_scheduler

Alien-side launch scheduler for the enemy bomb datapath. It owns a small pool of bomb instances, each a downward-moving copy of the player shot datapath with the same `en` / `shot_active` contract. Once every fire interval it picks one free bomb slot and one living alien column, using round-robin search from an LFSR start point. It then holds that slot's enable until the slot reports active. It sits between the alien formation controller (`col_alive`) and the bomb instances (`fire_en`, `fire_col`, `slot_busy`).

## Interface
- `NUM_COLS`, 11: alien columns; legal range 8..16.
- `NUM_SLOTS`, 3: bomb instances sharing the scheduler; legal range 1..4.
- `FIRE_INTERVAL`, 48: frames between an acknowledged launch and the next launch attempt; legal range 1..255.
- `ACK_TIMEOUT`, 4: frames a grant is held without acknowledge before it is abandoned.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- `s_clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk_0`  in  1  frame tick, a one-cycle pulse at 60 Hz.
- `pause`  in  1  game pause.
- `game_active`  in  1  play in progress; low aborts and idles the scheduler.
- `col_alive`  in  NUM_COLS  bit c is high when column c has at least one living alien.
- `slot_busy`  in  NUM_SLOTS  `shot_active` of each bomb instance.
- `fire_en`  out  NUM_SLOTS  launch request, one-hot or zero; drives the instance `en`.
- `fire_col`  out  4  selected column index; valid and stable while `fire_en` is non-zero.
- `fire_count`  out  8  wrapping count of acknowledged launches.

## Operation
- Reset values: state IDLE, interval counter = FIRE_INTERVAL, timeout counter = 0, `fire_en` = 0, `fire_col` = 0, `fire_count` = 0, LFSR = LFSR_SEED.
- LFSR: 16-bit Galois, mask 16'hB400, shift right. It advances every `s_clk` cycle outside reset, including during pause.
- **IDLE**
  - The interval counter decrements on `clk_0 && !pause && game_active`, saturating at 0.
  - When counter == 0, `game_active` is high, `pause` is low and any `slot_busy` bit is 0, the block latches slot = lowest-index free slot.
  - On the same condition it latches start = LFSR[3:0], minus NUM_COLS if that value is ≥ NUM_COLS. It then enters PICK.
- **PICK** checks one column per cycle, beginning at start.
  - If `col_alive[idx]` is high: `fire_col` = idx, enter GRANT.
  - Otherwise idx = idx+1, wrapping from NUM_COLS-1 to 0.
  - After NUM_COLS failed checks: reload the interval counter, return to IDLE, no grant.
- **GRANT**
  - `fire_en[slot]` = 1; `fire_col` is held.
  - Acknowledge is `slot_busy[slot]` == 1. On acknowledge: `fire_en` = 0, `fire_count`++, reload the interval counter, go to IDLE.
  - The timeout counter increments on `clk_0 && !pause`. When it reaches ACK_TIMEOUT: `fire_en` = 0, no count, reload the interval counter, go to IDLE.
- `pause` high freezes PICK and both counters. GRANT keeps `fire_en` asserted while paused.
- `game_active` low in any state: next cycle `fire_en` = 0, state IDLE, interval counter reloaded.
- `col_alive` changes during PICK are honoured per checked column. Changes during GRANT are ignored.

## Timing
- All outputs are registered.
- `fire_en` rises 1..NUM_COLS+1 cycles after the enabling IDLE condition.
- `fire_en` falls in the cycle after `slot_busy[slot]` is sampled high.
- A bomb instance samples `en` only on `clk_0`, so a grant normally lasts up to one frame.
- Acknowledge and timeout in the same cycle: acknowledge wins.
- `rst_n` low clears all state immediately, including mid-GRANT.

## Test plan
- Reset with FIRE_INTERVAL=4, all columns alive, slots free: `fire_en` = 0 through 3 ticks. After the 4th tick, `fire_en` = 3'b001 and `fire_col` equals the start index computed from the model LFSR.
- Raise `slot_busy[0]` while granting: `fire_en` = 0 on the next cycle, `fire_count` = 1, and the next grant occurs only after 4 more ticks.
- `col_alive` = only bit 7: `fire_col` = 7 for every seed tested. `col_alive` = 0: no grant within NUM_COLS+2 cycles, and the counter reloads.
- `slot_busy` = 3'b011: grant goes to slot 2 (`fire_en` = 3'b100). `slot_busy` = 3'b111: the block waits in IDLE. Freeing slot 1 produces `fire_en` = 3'b010 within NUM_COLS+2 cycles.
- Grant with no acknowledge: `fire_en` drops after the 4th tick, `fire_count` is unchanged, and the interval restarts.
- `pause` high mid-GRANT holds `fire_en` for 10 ticks with no timeout. Dropping `game_active` clears `fire_en` the next cycle. `rst_n` low clears `fire_en` within the same cycle.

Source files
------------

// File: rtl/bomb_scheduler.sv
// Enemy bomb launch scheduler: every fire interval it picks a free bomb slot and a living
// alien column (round-robin from an LFSR start point), then holds that slot's enable until the slot acknowledges.
module bomb_scheduler #(
  parameter int          NUM_COLS      = 11,
  parameter int          NUM_SLOTS     = 3,
  parameter int          FIRE_INTERVAL = 48,
  parameter int          ACK_TIMEOUT   = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                 s_clk,
  input  logic                 rst_n,
  input  logic                 clk_0,
  input  logic                 pause,
  input  logic                 game_active,
  input  logic [NUM_COLS-1:0]  col_alive,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  output logic [NUM_SLOTS-1:0] fire_en,
  output logic [3:0]           fire_col,
  output logic [7:0]           fire_count
);

  typedef enum logic [1:0] {IDLE, PICK, GRANT} state_e;

  localparam logic [7:0] INTERVAL_RELOAD = 8'(FIRE_INTERVAL);
  localparam logic [7:0] TIMEOUT_LIMIT   = 8'(ACK_TIMEOUT);
  localparam logic [4:0] NCOLS           = 5'(NUM_COLS);
  localparam logic [3:0] NCOLS_LO        = 4'(NUM_COLS);
  localparam logic [3:0] LAST_COL        = 4'(NUM_COLS - 1);
  localparam logic [4:0] LAST_CHECK      = 5'(NUM_COLS - 1);

  state_e               state_q;
  logic [7:0]           int_cnt_q;
  logic [7:0]           to_cnt_q;
  logic [15:0]          lfsr_q;
  logic [NUM_SLOTS-1:0] slot_oh_q;
  logic [3:0]           idx_q;
  logic [4:0]           checks_q;
  logic [NUM_SLOTS-1:0] fire_en_q;
  logic [3:0]           fire_col_q;
  logic [7:0]           fire_count_q;

  logic [15:0]          lfsr_d;
  logic [3:0]           start_d;
  logic [NUM_SLOTS-1:0] free_d;
  logic [NUM_SLOTS-1:0] free_oh_d;
  logic                 alive_d;
  logic                 ack_d;
  logic [7:0]           to_cnt_d;

  // NOTE: every always_comb output gets an unconditional assignment so no latch is inferred.
  always_comb begin
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    start_d   = ({1'b0, lfsr_q[3:0]} >= NCOLS) ? (lfsr_q[3:0] - NCOLS_LO) : lfsr_q[3:0];
    free_d    = ~slot_busy;
    free_oh_d = free_d & (~free_d + NUM_SLOTS'(1));  // isolates the lowest free slot
    alive_d   = |(col_alive & (NUM_COLS'(1) << idx_q));
    ack_d     = |(slot_busy & slot_oh_q);
    to_cnt_d  = to_cnt_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      int_cnt_q    <= INTERVAL_RELOAD;
      to_cnt_q     <= 8'd0;
      lfsr_q       <= LFSR_SEED;
      slot_oh_q    <= '0;
      idx_q        <= 4'd0;
      checks_q     <= 5'd0;
      fire_en_q    <= '0;
      fire_col_q   <= 4'd0;
      fire_count_q <= 8'd0;
    end else begin
      lfsr_q <= lfsr_d;
      if (!game_active) begin
        state_q   <= IDLE;
        fire_en_q <= '0;
        int_cnt_q <= INTERVAL_RELOAD;
        to_cnt_q  <= 8'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (clk_0 && !pause && int_cnt_q != 8'd0) int_cnt_q <= int_cnt_q - 8'd1;
            if (int_cnt_q == 8'd0 && !pause && |free_d) begin
              slot_oh_q <= free_oh_d;
              idx_q     <= start_d;
              checks_q  <= 5'd0;
              state_q   <= PICK;
            end
          end
          PICK: begin
            if (!pause) begin
              if (alive_d) begin
                fire_col_q <= idx_q;
                fire_en_q  <= slot_oh_q;
                to_cnt_q   <= 8'd0;
                state_q    <= GRANT;
              end else if (checks_q == LAST_CHECK) begin
                int_cnt_q <= INTERVAL_RELOAD;
                state_q   <= IDLE;
              end else begin
                idx_q    <= (idx_q == LAST_COL) ? 4'd0 : idx_q + 4'd1;
                checks_q <= checks_q + 5'd1;
              end
            end
          end
          GRANT: begin
            // Acknowledge is tested first so it wins over a simultaneous timeout.
            if (ack_d) begin
              fire_en_q    <= '0;
              fire_count_q <= fire_count_q + 8'd1;
              int_cnt_q    <= INTERVAL_RELOAD;
              to_cnt_q     <= 8'd0;
              state_q      <= IDLE;
            end else if (clk_0 && !pause) begin
              if (to_cnt_d >= TIMEOUT_LIMIT) begin
                fire_en_q <= '0;
                int_cnt_q <= INTERVAL_RELOAD;
                to_cnt_q  <= 8'd0;
                state_q   <= IDLE;
              end else begin
                to_cnt_q <= to_cnt_d;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign fire_en    = fire_en_q;
  assign fire_col   = fire_col_q;
  assign fire_count = fire_count_q;

endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed bench for bomb_scheduler: a table of slot/column scenarios plus hand-written
// sequences for empty formation, timeout, pause, game abort and asynchronous reset.
module tb_bomb_scheduler;

  localparam int          NCOLS = 11;
  localparam int          NSLOT = 3;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic             s_clk = 1'b0;
  logic             rst_n;
  logic             clk_0;
  logic             pause;
  logic             game_active;
  logic [NCOLS-1:0] col_alive;
  logic [NSLOT-1:0] slot_busy;
  logic [NSLOT-1:0] fire_en;
  logic [3:0]       fire_col;
  logic [7:0]       fire_count;

  int n_checks = 0;
  int n_fail   = 0;

  bomb_scheduler #(
    .NUM_COLS(NCOLS), .NUM_SLOTS(NSLOT), .FIRE_INTERVAL(4), .ACK_TIMEOUT(4), .LFSR_SEED(SEED)
  ) dut (
    .s_clk(s_clk), .rst_n(rst_n), .clk_0(clk_0), .pause(pause), .game_active(game_active),
    .col_alive(col_alive), .slot_busy(slot_busy),
    .fire_en(fire_en), .fire_col(fire_col), .fire_count(fire_count)
  );

  always #5 s_clk = ~s_clk;

  // Reference LFSR; h2 holds the value from two edges back, which is the start
  // point used by a grant that becomes visible now after a one-cycle PICK.
  logic [15:0] lfsr_m, h1, h2;
  always @(posedge s_clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_m <= SEED; h1 <= SEED; h2 <= SEED;
    end else begin
      lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
      h1     <= lfsr_m;
      h2     <= h1;
    end
  end

  function automatic logic [3:0] model_start(input logic [15:0] v);
    logic [3:0] n;
    n = v[3:0];
    if (n >= 4'(NCOLS)) n = n - 4'(NCOLS);
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge s_clk); clk_0 = 1'b1;
    @(negedge s_clk); clk_0 = 1'b0;
  endtask

  task automatic wait_grant(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge s_clk);
      if (fire_en != '0) break;
    end
  endtask

  typedef struct packed {
    logic [NSLOT-1:0] busy;
    logic [NCOLS-1:0] alive;
    logic [NSLOT-1:0] exp_en;
    logic             use_model;
    logic [3:0]       exp_col;
  } vec_t;

  vec_t vecs[8];
  localparam logic [NCOLS-1:0] ALL = '1;

  initial begin
    logic [7:0] exp_count;
    logic [3:0] exp_col;

    vecs[0] = '{busy: 3'b000, alive: ALL,          exp_en: 3'b001, use_model: 1'b1, exp_col: 4'd0};
    vecs[1] = '{busy: 3'b000, alive: 11'h080,      exp_en: 3'b001, use_model: 1'b0, exp_col: 4'd7};
    vecs[2] = '{busy: 3'b011, alive: 11'h080,      exp_en: 3'b100, use_model: 1'b0, exp_col: 4'd7};
    vecs[3] = '{busy: 3'b001, alive: 11'h001,      exp_en: 3'b010, use_model: 1'b0, exp_col: 4'd0};
    vecs[4] = '{busy: 3'b110, alive: 11'h400,      exp_en: 3'b001, use_model: 1'b0, exp_col: 4'd10};
    vecs[5] = '{busy: 3'b010, alive: ALL,          exp_en: 3'b001, use_model: 1'b1, exp_col: 4'd0};
    vecs[6] = '{busy: 3'b101, alive: 11'h080,      exp_en: 3'b010, use_model: 1'b0, exp_col: 4'd7};
    vecs[7] = '{busy: 3'b000, alive: 11'h080,      exp_en: 3'b001, use_model: 1'b0, exp_col: 4'd7};

    rst_n = 1'b0; clk_0 = 1'b0; pause = 1'b0; game_active = 1'b1;
    col_alive = ALL; slot_busy = '0;
    repeat (3) @(negedge s_clk);
    check("reset fire_en", 32'(fire_en), 32'd0);
    check("reset fire_col", 32'(fire_col), 32'd0);
    check("reset fire_count", 32'(fire_count), 32'd0);
    rst_n = 1'b1;
    exp_count = 8'd0;

    // Table: each entry runs a full interval, checks the grant, then acknowledges it.
    for (int v = 0; v < 8; v++) begin
      slot_busy = vecs[v].busy;
      col_alive = vecs[v].alive;
      repeat (3) tick();
      repeat (3) @(negedge s_clk);
      check($sformatf("vec%0d no grant before 4th tick", v), 32'(fire_en), 32'd0);
      tick();
      wait_grant(NCOLS + 3);
      exp_col = vecs[v].use_model ? model_start(h2) : vecs[v].exp_col;
      check($sformatf("vec%0d fire_en", v), 32'(fire_en), 32'(vecs[v].exp_en));
      check($sformatf("vec%0d fire_col", v), 32'(fire_col), 32'(exp_col));
      slot_busy = vecs[v].busy | vecs[v].exp_en;
      @(negedge s_clk);
      exp_count++;
      check($sformatf("vec%0d fire_en after ack", v), 32'(fire_en), 32'd0);
      check($sformatf("vec%0d fire_count", v), 32'(fire_count), 32'(exp_count));
    end

    // Empty formation: full scan fails, no grant, interval reloads.
    slot_busy = '0;
    col_alive = '0;
    repeat (4) tick();
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < NCOLS + 4; i++) begin
        @(negedge s_clk);
        if (fire_en != '0) seen = 1'b1;
      end
      check("empty formation no grant", 32'(seen), 32'd0);
    end
    col_alive = ALL;
    repeat (3) tick();
    repeat (3) @(negedge s_clk);
    check("reload after empty scan", 32'(fire_en), 32'd0);
    tick();
    wait_grant(NCOLS + 3);
    check("grant after reload fire_en", 32'(fire_en), 32'd1);
    check("grant after reload fire_col", 32'(fire_col), 32'(model_start(h2)));

    // No acknowledge: grant abandoned on the 4th tick.
    repeat (3) tick();
    check("grant held before timeout", 32'(fire_en), 32'd1);
    tick();
    check("fire_en dropped on timeout", 32'(fire_en), 32'd0);
    check("count unchanged on timeout", 32'(fire_count), 32'(exp_count));
    repeat (3) tick();
    repeat (3) @(negedge s_clk);
    check("interval restarted after timeout", 32'(fire_en), 32'd0);
    tick();
    wait_grant(NCOLS + 3);
    check("regrant after timeout fire_en", 32'(fire_en), 32'd1);
    check("regrant after timeout fire_col", 32'(fire_col), 32'(model_start(h2)));

    // Pause holds the grant with no timeout.
    pause = 1'b1;
    repeat (10) tick();
    check("grant held through pause", 32'(fire_en), 32'd1);

    // Game abort clears the grant on the next cycle.
    pause = 1'b0;
    game_active = 1'b0;
    @(negedge s_clk);
    check("fire_en cleared by game abort", 32'(fire_en), 32'd0);
    check("count unchanged by abort", 32'(fire_count), 32'(exp_count));
    game_active = 1'b1;

    // All slots busy: wait in IDLE; freeing slot 1 then grants it.
    slot_busy = 3'b111;
    repeat (4) tick();
    repeat (NCOLS + 4) @(negedge s_clk);
    check("all slots busy waits", 32'(fire_en), 32'd0);
    slot_busy = 3'b101;
    wait_grant(NCOLS + 2);
    check("freed slot 1 fire_en", 32'(fire_en), 32'b010);
    check("freed slot 1 fire_col", 32'(fire_col), 32'(model_start(h2)));

    // Asynchronous reset mid-grant clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset fire_en", 32'(fire_en), 32'd0);
    check("async reset fire_count", 32'(fire_count), 32'd0);
    @(negedge s_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge s_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
